datapath_ctrl_fsm: RTL and testbench

- Instruction decoder plus Moore state machine that sequences the 8x16 register-file / shifter / ALU datapath for one instruction at a time.
- Captures a 16-bit instruction on a start handshake and drives every datapath strobe and select: `vsel`, `loada`, `loadb`, `asel`, `bsel`, `loadc`, `loads`, `write`, `readnum`, `writenum`, `shift`, `ALUop`.
- Also drives the sign-extended immediates `sximm8` and `sximm5`.
- Sits between the instruction source (testbench or future fetch unit) and the datapath.

---
 rtl/datapath_ctrl_fsm.sv | 192 +++++++++++++++++++
 tb/tb_datapath_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl_fsm.sv
// datapath_ctrl_fsm
// Instruction decoder and Moore sequencer for the 8x16 register-file /
// shifter / ALU datapath. One instruction is executed at a time.
//
// Handshake: s is a start request, w is "ready". An instruction on in_instr
// is accepted on any rising clk edge where s=1 and w=1 (w is high only in
// WAIT). s while w=0 is ignored, so ir stays stable for the whole instruction.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   s, in_instr          start request and instruction word
//   w, err               idle/ready, registered illegal-instruction flag
//   vsel                 one-hot writeback select (0001 mdata, 0010 sximm8,
//                        0100 PC, 1000 C)
//   loada/loadb/loadc/loads/write   datapath strobes
//   asel, bsel           ALU operand selects
//   readnum, writenum    register-file selects
//   shift, ALUop         shifter and ALU op codes
//   sximm8, sximm5       sign-extended ir[7:0] / ir[4:0]
//   dbg_state            current FSM state encoding, for observation only
//
// Optional feature: define DATAPATH_CTRL_HALT_EN to decode opcode 111 as
// HALT (stops until reset). Without it, opcode 111 is illegal.
module datapath_ctrl_fsm #(
  parameter int DATA_W = 16,
  parameter int RSEL_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [DATA_W-1:0] in_instr,
  output logic              w,
  output logic              err,
  output logic [3:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic              asel,
  output logic              bsel,
  output logic [RSEL_W-1:0] readnum,
  output logic [RSEL_W-1:0] writenum,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_ALU    = 3'd5,
`ifdef DATAPATH_CTRL_HALT_EN
    S_WR_REG = 3'd6,
    S_HALT   = 3'd7
`else
    S_WR_REG = 3'd6
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              err_q, err_d;

  // Instruction fields
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  // Instruction classes
  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_halt;
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_halt    = (opcode == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // Next state, ir/err update, and Moore outputs.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    err_d    = err_q;
    w        = 1'b0;
    vsel     = 4'b0001;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    readnum  = '0;
    writenum = '0;
    shift    = 2'b00;
    ALUop    = 2'b00;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) begin
          state_d = S_DECODE;
          ir_d    = in_instr;
          err_d   = 1'b0;
        end
      end
      S_DECODE: begin
        if (is_mov_imm)                  state_d = S_WR_IMM;
        else if (is_mov_reg || is_mvn)   state_d = S_GET_B;
        else if (is_alu)                 state_d = S_GET_A;
`ifdef DATAPATH_CTRL_HALT_EN
        else if (is_halt)                state_d = S_HALT;
`endif
        else begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end
      end
      S_WR_IMM: begin
        vsel     = 4'b0010;
        writenum = RSEL_W'(rn);
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = RSEL_W'(rn);
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = RSEL_W'(rm);
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        ALUop = op;
        // Single-operand forms zero the A input so the ALU passes/inverts B.
        asel  = is_mov_reg || is_mvn;
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WR_REG;
        end
      end
      S_WR_REG: begin
        vsel     = 4'b1000;
        writenum = RSEL_W'(rd);
        write    = 1'b1;
        state_d  = S_WAIT;
      end
`ifdef DATAPATH_CTRL_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_WAIT;
    endcase
  end

  // is_halt only steers the FSM when the HALT feature is built in.
  logic unused_halt;
  assign unused_halt = is_halt;

  assign err       = err_q;
  assign sximm8    = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5    = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
module tb_datapath_ctrl_fsm;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic [15:0] in_instr;
  logic        w, err;
  logic [3:0]  vsel;
  logic        loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  datapath_ctrl_fsm dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in_instr(in_instr),
    .w(w), .err(err), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .asel(asel), .bsel(bsel), .readnum(readnum), .writenum(writenum),
    .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5),
    .dbg_state(dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       w;
    logic       loada, loadb, loadc, loads, write, asel, bsel;
    logic [3:0] vsel;
    logic [2:0] readnum, writenum;
    logic [1:0] shift, aluop;
  } vec_t;

  vec_t exp_q[$];     // expected output vector per cycle after acceptance
  logic exp_illegal;
  logic exp_halt;
  logic model_err;

  int checks = 0;
  int errors = 0;

  function automatic vec_t busy_vec();
    vec_t v = '0;
    v.vsel = 4'b0001;
    return v;
  endfunction

  function automatic vec_t wait_vec();
    vec_t v = busy_vec();
    v.w = 1'b1;
    return v;
  endfunction

  function automatic vec_t obs_vec();
    vec_t v;
    v.w = w; v.loada = loada; v.loadb = loadb; v.loadc = loadc;
    v.loads = loads; v.write = write; v.asel = asel; v.bsel = bsel;
    v.vsel = vsel; v.readnum = readnum; v.writenum = writenum;
    v.shift = shift; v.aluop = ALUop;
    return v;
  endfunction

  // Sign extension by arithmetic on the field value.
  function automatic logic [15:0] sx(input int val, input int bits);
    int v = val;
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  // Cycle-by-cycle expected outputs derived from the instruction class.
  task automatic build_seq(input logic [15:0] instr);
    int opc = int'(instr[15:13]);
    int op  = int'(instr[12:11]);
    int rn  = int'(instr[10:8]);
    int rd  = int'(instr[7:5]);
    int sh  = int'(instr[4:3]);
    int rm  = int'(instr[2:0]);
    vec_t v;
    logic mov_imm, one_op, two_op, is_cmp;
    mov_imm = (opc == 6) && (op == 2);
    one_op  = ((opc == 6) && (op == 0)) || ((opc == 5) && (op == 3));
    two_op  = (opc == 5) && (op != 3);
    is_cmp  = (opc == 5) && (op == 1);
    exp_q.delete();
    exp_halt    = 1'b0;
    exp_illegal = 1'b0;
    exp_q.push_back(busy_vec());                       // DECODE
    if (mov_imm) begin
      v = busy_vec(); v.vsel = 4'b0010; v.writenum = 3'(rn); v.write = 1'b1;
      exp_q.push_back(v);
    end else if (one_op || two_op) begin
      if (two_op) begin
        v = busy_vec(); v.readnum = 3'(rn); v.loada = 1'b1; exp_q.push_back(v);
      end
      v = busy_vec(); v.readnum = 3'(rm); v.loadb = 1'b1; exp_q.push_back(v);
      v = busy_vec(); v.shift = 2'(sh); v.aluop = 2'(op); v.asel = one_op;
      if (is_cmp) v.loads = 1'b1; else v.loadc = 1'b1;
      exp_q.push_back(v);
      if (!is_cmp) begin
        v = busy_vec(); v.vsel = 4'b1000; v.writenum = 3'(rd); v.write = 1'b1;
        exp_q.push_back(v);
      end
    end else begin
`ifdef DATAPATH_CTRL_HALT_EN
      if (opc == 7) exp_halt = 1'b1;
      else          exp_illegal = 1'b1;
`else
      exp_illegal = 1'b1;
`endif
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " vec"}, 32'(obs_vec()), 32'(wait_vec()));
    check({tag, " err"}, 32'(err), 32'(model_err));
  endtask

  // ---------------- driver ----------------
  // Issue one instruction and check every cycle until WAIT returns.
  // rst_idx >= 0 asserts reset asynchronously while in that step.
  task automatic run_instr(input logic [15:0] instr, input int rst_idx);
    string t;
    @(negedge clk);
    check_idle($sformatf("idle before %h", instr));
    build_seq(instr);
    s = 1'b1;
    in_instr = instr;
    @(posedge clk);
    model_err = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      t = $sformatf("instr %h step %0d", instr, k);
      check({t, " vec"}, 32'(obs_vec()), 32'(exp_q[k]));
      check({t, " err"}, 32'(err), 32'(1'b0));
      check({t, " sximm8"}, 32'(sximm8), 32'(sx(int'(instr[7:0]), 8)));
      check({t, " sximm5"}, 32'(sximm5), 32'(sx(int'(instr[4:0]), 5)));
      if (k == rst_idx) begin
        #2 reset_n = 1'b0;
        #1;
        check({t, " async reset vec"}, 32'(obs_vec()), 32'(wait_vec()));
        check({t, " async reset err"}, 32'(err), 32'(1'b0));
        check({t, " async reset sximm8"}, 32'(sximm8), 32'(0));
        s = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_err = 1'b0;
        return;
      end
      // Busy cycles get random s/in_instr, which must be ignored.
      if (k == exp_q.size() - 1 && !exp_halt) s = 1'b0;
      else s = 1'($urandom_range(0, 1));
      in_instr = 16'($urandom);
    end
    if (exp_halt) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("halt %h hold %0d", instr, k), 32'(obs_vec()), 32'(busy_vec()));
        s = 1'($urandom_range(0, 1));
      end
      s = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("halt reset vec", 32'(obs_vec()), 32'(wait_vec()));
      @(negedge clk);
      reset_n = 1'b1;
      model_err = 1'b0;
    end else begin
      model_err = exp_illegal;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [10:0] low = 11'($urandom);
    logic [2:0]  opc;
    case ($urandom_range(0, 7))
      0: return {3'b110, 2'b10, low};
      1: return {3'b110, 2'b00, low};
      2, 3, 4: return {3'b101, 2'($urandom_range(0, 2)), low};
      5: return {3'b101, 2'b11, low};
      6: begin
        opc = 3'($urandom_range(0, 4));
        if (opc == 3'd4) return {3'b110, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11, low};
        return {opc, 2'($urandom), low};
      end
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n   = 1'b0;
    s         = 1'b0;
    in_instr  = 16'h0000;
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset sximm8", 32'(sximm8), 32'(0));
    check("reset sximm5", 32'(sximm5), 32'(0));
    reset_n = 1'b1;

    run_instr(16'hD3FB, -1);   // MOV R3,#-5
    run_instr(16'hA148, -1);   // ADD R2,R1,R0,LSL#1
    run_instr(16'hAD06, -1);   // CMP R5,R6
    run_instr(16'hB8E4, -1);   // MVN R7,R4
    run_instr(16'h0000, -1);   // illegal -> err
    run_instr(16'hC0E5, -1);   // MOV R7,R5 clears err
    run_instr(16'hE000, -1);   // opcode 111

    for (int i = 0; i < 60; i++) run_instr(rand_instr(), -1);

    run_instr(16'hA148, 2);    // reset during GET_B of ADD
    run_instr(16'hD3FB, -1);
    @(negedge clk);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
